// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I main controller: opcodes, state
// encoding, datapath mux selects and trap causes.
package mc_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXR,
        S_EXI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_JALRLINK,
        S_UPPER,
        S_MDWAIT,
        S_TRAP
    } state_t;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] RES_MD     = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_BUS     = 2'b10;

    // Per-state control word; the top gates the whole word to zero during reset.
    typedef struct packed {
        logic       mem_req;
        logic       pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] alu_op;
        logic       md_start;
        logic       trap;
    } ctrl_t;

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_main_fsm_if.sv
// Memory and mul/div handshake bundle between the main controller and the
// units it sequences.
interface mc_main_fsm_if;
    logic mem_req;
    logic mem_ready;
    logic md_start;
    logic md_done;

    modport master (output mem_req, output md_start, input mem_ready, input md_done);
    modport slave  (input mem_req, input md_start, output mem_ready, output md_done);
endinterface

// File: rtl/imm_src_dec.sv
// Opcode to immediate-format select; also used by the legacy single-cycle core.
module imm_src_dec
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [2:0] imm_src
);

    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_STORE:         imm_src = IMM_S;
            OP_BRANCH:        imm_src = IMM_B;
            OP_JAL:           imm_src = IMM_J;
            OP_LUI, OP_AUIPC: imm_src = IMM_U;
            default:          imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/mc_main_fsm.sv
// Multicycle main controller: sequences fetch/decode/execute/memory/writeback,
// stalls on the memory ready handshake and optionally drives a mul/div unit.
module mc_main_fsm
    import mc_ctrl_pkg::*;
#(
    parameter bit ENABLE_M    = 1'b0,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       funct7_b0,
    mc_main_fsm_if.master bus,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       Branch,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       trap,
    output logic [1:0] trap_cause
);

    localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);

    state_t           state, next_state;
    logic [CNT_W-1:0] wait_cnt, wait_next;
    logic [1:0]       cause_q, cause_next;
    logic             timed_out;
    ctrl_t            ctrl, ctrl_out;

    imm_src_dec u_imm_src_dec (
        .op      (op),
        .imm_src (ImmSrc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            cause_q  <= CAUSE_NONE;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_next;
            cause_q  <= cause_next;
        end
    end

    // The counter only runs while a memory state is stalled, so it is zero on entry.
    always_comb begin
        timed_out = (MEM_TIMEOUT != 0) && (wait_cnt == TIMEOUT_VAL);
        wait_next = '0;
        if (is_mem_state(state) && !bus.mem_ready) begin
            wait_next = wait_cnt + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        cause_next = cause_q;
        ctrl       = '0;
        unique case (state)
            S_FETCH: begin
                ctrl.mem_req    = 1'b1;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALURES;
                if (bus.mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    next_state    = S_DECODE;
                end else if (timed_out) begin
                    next_state = S_TRAP;
                    cause_next = CAUSE_BUS;
                end
            end
            S_DECODE: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_RTYPE: begin
                        if (ENABLE_M && funct7_b0) begin
                            ctrl.md_start = 1'b1;
                            next_state    = S_MDWAIT;
                        end else begin
                            next_state = S_EXR;
                        end
                    end
                    OP_IALU:          next_state = S_EXI;
                    OP_BRANCH:        next_state = S_BRANCH;
                    OP_JAL:           next_state = S_JAL;
                    OP_JALR:          next_state = S_JALR;
                    OP_LUI, OP_AUIPC: next_state = S_UPPER;
                    default: begin
                        next_state = S_TRAP;
                        cause_next = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_REG;
                ctrl.alu_src_b = SRCB_IMM;
                next_state     = (op == OP_STORE) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.adr_src = 1'b1;
                if (bus.mem_ready) begin
                    next_state = S_MEMWB;
                end else if (timed_out) begin
                    next_state = S_TRAP;
                    cause_next = CAUSE_BUS;
                end
            end
            S_MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_write  = 1'b1;
                next_state      = S_FETCH;
            end
            S_MEMWR: begin
                ctrl.mem_req   = 1'b1;
                ctrl.adr_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                if (bus.mem_ready) begin
                    next_state = S_FETCH;
                end else if (timed_out) begin
                    next_state = S_TRAP;
                    cause_next = CAUSE_BUS;
                end
            end
            S_EXR: begin
                ctrl.alu_src_a = SRCA_REG;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
                next_state     = S_ALUWB;
            end
            S_EXI: begin
                ctrl.alu_src_a = SRCA_REG;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_FUNCT;
                next_state     = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
                next_state      = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = SRCA_REG;
                ctrl.alu_src_b  = SRCB_REG;
                ctrl.alu_op     = ALUOP_BR;
                ctrl.result_src = RES_ALUOUT;
                ctrl.branch     = 1'b1;
                next_state      = S_FETCH;
            end
            S_JAL: begin
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = 1'b1;
                next_state      = S_ALUWB;
            end
            S_JALR: begin
                ctrl.alu_src_a  = SRCA_REG;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.result_src = RES_ALURES;
                ctrl.pc_write   = 1'b1;
                next_state      = S_JALRLINK;
            end
            S_JALRLINK: begin
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALURES;
                ctrl.reg_write  = 1'b1;
                next_state      = S_FETCH;
            end
            S_UPPER: begin
                ctrl.alu_src_a = (op == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                next_state     = S_ALUWB;
            end
            S_MDWAIT: begin
                if (bus.md_done) begin
                    ctrl.result_src = RES_MD;
                    ctrl.reg_write  = 1'b1;
                    next_state      = S_FETCH;
                end
            end
            S_TRAP: begin
                ctrl.trap = 1'b1;
            end
        endcase
    end

    // Reset forces every control output low at once, aborting any bus access.
    assign ctrl_out = rst_n ? ctrl : '0;

    assign bus.mem_req  = ctrl_out.mem_req;
    assign bus.md_start = ctrl_out.md_start;
    assign PCWrite      = ctrl_out.pc_write;
    assign IRWrite      = ctrl_out.ir_write;
    assign RegWrite     = ctrl_out.reg_write;
    assign MemWrite     = ctrl_out.mem_write;
    assign Branch       = ctrl_out.branch;
    assign AdrSrc       = ctrl_out.adr_src;
    assign ALUSrcA      = ctrl_out.alu_src_a;
    assign ALUSrcB      = ctrl_out.alu_src_b;
    assign ResultSrc    = ctrl_out.result_src;
    assign ALUOp        = ctrl_out.alu_op;
    assign trap         = ctrl_out.trap;
    assign trap_cause   = cause_q;

endmodule

// File: tb/tb_mc_main_fsm.sv
// Self-checking bench for mc_main_fsm: latency table, directed handshake and
// reset sequences, and random instruction streams against a cycle-sequence model.
module tb_mc_main_fsm;

    typedef struct packed {
        logic       mem_req, pcw, irw, rw, mw, br, adr;
        logic [1:0] a, b, res, aop;
        logic       md_start, trap;
        logic [1:0] cause;
    } word_t;

    typedef struct {
        word_t w;
        logic  ready;
        logic  done;
    } step_t;

    typedef struct {
        logic [6:0] op;
        logic       f7;
        int         lat0;
        int         lat1;
        logic [2:0] imm;
    } vec_t;

    localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RR = 7'b0110011,
                           IA = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111,
                           JR = 7'b1100111, LU = 7'b0110111, AU = 7'b0010111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [6:0] op = 7'b0;
    logic f7 = 1'b0;

    logic pcw0, irw0, rw0, mw0, br0, adr0, trap0;
    logic pcw1, irw1, rw1, mw1, br1, adr1, trap1;
    logic [1:0] a0, b0, res0, aop0, cause0, a1, b1, res1, aop1, cause1;
    logic [2:0] imm0, imm1;
    word_t act0, act1;

    int checks = 0;
    int errors = 0;
    step_t sched[$];

    mc_main_fsm_if bus0 ();
    mc_main_fsm_if bus1 ();

    mc_main_fsm dut0 (
        .clk(clk), .rst_n(rst_n), .op(op), .funct7_b0(f7), .bus(bus0),
        .PCWrite(pcw0), .IRWrite(irw0), .RegWrite(rw0), .MemWrite(mw0),
        .Branch(br0), .AdrSrc(adr0), .ALUSrcA(a0), .ALUSrcB(b0),
        .ResultSrc(res0), .ALUOp(aop0), .ImmSrc(imm0), .trap(trap0),
        .trap_cause(cause0)
    );

    mc_main_fsm #(.ENABLE_M(1'b1), .MEM_TIMEOUT(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .op(op), .funct7_b0(f7), .bus(bus1),
        .PCWrite(pcw1), .IRWrite(irw1), .RegWrite(rw1), .MemWrite(mw1),
        .Branch(br1), .AdrSrc(adr1), .ALUSrcA(a1), .ALUSrcB(b1),
        .ResultSrc(res1), .ALUOp(aop1), .ImmSrc(imm1), .trap(trap1),
        .trap_cause(cause1)
    );

    assign act0 = {bus0.mem_req, pcw0, irw0, rw0, mw0, br0, adr0, a0, b0, res0, aop0,
                   bus0.md_start, trap0, cause0};
    assign act1 = {bus1.mem_req, pcw1, irw1, rw1, mw1, br1, adr1, a1, b1, res1, aop1,
                   bus1.md_start, trap1, cause1};

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic ready, input logic done);
        bus0.mem_ready = ready;
        bus1.mem_ready = ready;
        bus0.md_done   = done;
        bus1.md_done   = done;
    endtask

    // Leaves time at posedge+1 with reset just released: the next cycle is FETCH.
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        apply_stimulus(1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic logic [2:0] imm_exp(input logic [6:0] o);
        if (o == ST) return 3'b001;
        if (o == BR) return 3'b010;
        if (o == JL) return 3'b011;
        if (o == LU || o == AU) return 3'b100;
        return 3'b000;
    endfunction

    // flags = {mem_req, PCWrite, IRWrite, RegWrite, MemWrite, Branch, AdrSrc}
    function automatic word_t w(input logic [6:0] flags, input logic [1:0] a, input logic [1:0] b,
                                input logic [1:0] res, input logic [1:0] aop);
        word_t x;
        x = '0;
        {x.mem_req, x.pcw, x.irw, x.rw, x.mw, x.br, x.adr} = flags;
        x.a = a; x.b = b; x.res = res; x.aop = aop;
        return x;
    endfunction

    task automatic push_step(input word_t x, input logic ready, input logic done);
        step_t s;
        s.w = x; s.ready = ready; s.done = done;
        sched.push_back(s);
    endtask

    task automatic push_mem(input word_t wait_w, input word_t go_w, input int n);
        for (int i = 0; i < n; i++) push_step(wait_w, 1'b0, 1'b0);
        push_step(go_w, 1'b1, 1'b0);
    endtask

    // Reference: expected per-cycle control words of one instruction on the ENABLE_M=1 core.
    task automatic run_instr(input logic [6:0] o, input logic fb, input int fw, input int mw, input int lat);
        word_t dec, aluwb, memrd, memwr;
        aluwb = w(7'b0001000, 2'b00, 2'b00, 2'b00, 2'b00);
        memrd = w(7'b1000001, 2'b00, 2'b00, 2'b00, 2'b00);
        memwr = w(7'b1000101, 2'b00, 2'b00, 2'b00, 2'b00);
        sched.delete();
        push_mem(w(7'b1000000, 2'b00, 2'b10, 2'b10, 2'b00), w(7'b1110000, 2'b00, 2'b10, 2'b10, 2'b00), fw);
        dec = w(7'b0, 2'b01, 2'b01, 2'b00, 2'b00);
        dec.md_start = (o == RR) && fb;
        push_step(dec, 1'($urandom), 1'b0);
        case (o)
            LD: begin
                push_step(w(7'b0, 2'b10, 2'b01, 2'b00, 2'b00), 1'($urandom), 1'b0);
                push_mem(memrd, memrd, mw);
                push_step(w(7'b0001000, 2'b00, 2'b00, 2'b01, 2'b00), 1'($urandom), 1'b0);
            end
            ST: begin
                push_step(w(7'b0, 2'b10, 2'b01, 2'b00, 2'b00), 1'($urandom), 1'b0);
                push_mem(memwr, memwr, mw);
            end
            RR: begin
                if (fb) begin
                    for (int i = 1; i < lat; i++) push_step(w(7'b0, 2'b00, 2'b00, 2'b00, 2'b00), 1'($urandom), 1'b0);
                    push_step(w(7'b0001000, 2'b00, 2'b00, 2'b11, 2'b00), 1'($urandom), 1'b1);
                end else begin
                    push_step(w(7'b0, 2'b10, 2'b00, 2'b00, 2'b10), 1'($urandom), 1'b0);
                    push_step(aluwb, 1'($urandom), 1'b0);
                end
            end
            IA: begin
                push_step(w(7'b0, 2'b10, 2'b01, 2'b00, 2'b10), 1'($urandom), 1'b0);
                push_step(aluwb, 1'($urandom), 1'b0);
            end
            BR: push_step(w(7'b0000010, 2'b10, 2'b00, 2'b00, 2'b01), 1'($urandom), 1'b0);
            JL: begin
                push_step(w(7'b0100000, 2'b01, 2'b10, 2'b00, 2'b00), 1'($urandom), 1'b0);
                push_step(aluwb, 1'($urandom), 1'b0);
            end
            JR: begin
                push_step(w(7'b0100000, 2'b10, 2'b01, 2'b10, 2'b00), 1'($urandom), 1'b0);
                push_step(w(7'b0001000, 2'b01, 2'b10, 2'b10, 2'b00), 1'($urandom), 1'b0);
            end
            default: begin
                push_step(w(7'b0, (o == LU) ? 2'b11 : 2'b01, 2'b01, 2'b00, 2'b00), 1'($urandom), 1'b0);
                push_step(aluwb, 1'($urandom), 1'b0);
            end
        endcase
        op = o;
        f7 = fb;
        foreach (sched[i]) begin
            apply_stimulus(sched[i].ready, sched[i].done);
            @(negedge clk);
            if (i == 0) check_output($sformatf("imm op=%b", o), 32'(imm1), 32'(imm_exp(o)));
            check_output($sformatf("word op=%b cyc%0d", o, i), 32'(act1), 32'(sched[i].w));
            @(posedge clk);
            #1;
        end
        apply_stimulus(1'b0, 1'b0);
    endtask

    vec_t tbl [12];
    logic [6:0] legal [10];

    initial begin
        int lat0, lat1, tr0, tr1;
        tbl = '{
            '{RR, 1'b0, 4, 4, 3'b000}, '{RR, 1'b1, 4, 5, 3'b000},
            '{IA, 1'b0, 4, 4, 3'b000}, '{LD, 1'b0, 5, 5, 3'b000},
            '{ST, 1'b0, 4, 4, 3'b001}, '{BR, 1'b0, 3, 3, 3'b010},
            '{JL, 1'b0, 4, 4, 3'b011}, '{JR, 1'b0, 4, 4, 3'b000},
            '{LU, 1'b0, 4, 4, 3'b100}, '{AU, 1'b0, 4, 4, 3'b100},
            '{7'b0000000, 1'b0, -1, -1, 3'b000}, '{7'b1111111, 1'b1, -1, -1, 3'b000}
        };
        legal = '{LD, ST, RR, RR, IA, BR, JL, JR, LU, AU};

        // Reset state: every output low except ImmSrc
        op = ST;
        apply_stimulus(1'b1, 1'b0);
        @(negedge clk);
        check_output("reset word dut1", 32'(act1), 32'h0);
        check_output("reset word dut0", 32'(act0), 32'h0);
        check_output("reset imm", 32'(imm1), 32'h1);

        // Latency table at zero-wait memory, unit latency 3
        for (int r = 0; r < 12; r++) begin
            apply_reset();
            op = tbl[r].op;
            f7 = tbl[r].f7;
            lat0 = -1; lat1 = -1; tr0 = -1; tr1 = -1;
            for (int c = 0; c < 16; c++) begin
                apply_stimulus(1'b1, c == 4);
                @(negedge clk);
                if (c == 0) check_output($sformatf("tbl%0d imm", r), 32'(imm0), 32'(tbl[r].imm));
                if (c > 0 && lat0 < 0 && bus0.mem_req && !adr0) lat0 = c;
                if (c > 0 && lat1 < 0 && bus1.mem_req && !adr1) lat1 = c;
                if (tr0 < 0 && trap0) tr0 = c;
                if (tr1 < 0 && trap1) tr1 = c;
                @(posedge clk);
                #1;
            end
            check_output($sformatf("tbl%0d lat dut0", r), 32'(lat0), 32'(tbl[r].lat0));
            check_output($sformatf("tbl%0d lat dut1", r), 32'(lat1), 32'(tbl[r].lat1));
            check_output($sformatf("tbl%0d trap dut0", r), 32'(tr0), (tbl[r].lat0 < 0) ? 32'd2 : -32'd1);
            check_output($sformatf("tbl%0d trap dut1", r), 32'(tr1), (tbl[r].lat1 < 0) ? 32'd2 : -32'd1);
            check_output($sformatf("tbl%0d cause", r), 32'(cause1), (tbl[r].lat1 < 0) ? 32'd1 : 32'd0);
        end

        // Fetch timeout: 4 stalled cycles, then the compare cycle, then TRAP
        apply_reset();
        op = RR;
        for (int c = 0; c < 8; c++) begin
            apply_stimulus(1'b0, 1'b0);
            @(negedge clk);
            check_output($sformatf("tmo trap c%0d", c), 32'(trap1), 32'(c >= 5));
            check_output($sformatf("tmo cause c%0d", c), 32'(cause1), (c >= 5) ? 32'd2 : 32'd0);
            check_output($sformatf("tmo dut0 c%0d", c), 32'(trap0), 32'd0);
            @(posedge clk);
            #1;
        end
        for (int c = 0; c < 6; c++) begin
            apply_stimulus(1'b1, 1'b1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check_output("tmo sticky", 32'(act1), 32'(w(7'b0, 2'b00, 2'b00, 2'b00, 2'b00)) | 32'h6);
        rst_n = 1'b0;
        #1 check_output("tmo cleared", 32'({trap1, cause1}), 32'h0);

        // Ready in the compare cycle wins over the timeout
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            apply_stimulus(c == 4, 1'b0);
            @(negedge clk);
            if (c == 4) check_output("tmo edge irw", 32'(irw1), 32'd1);
            check_output($sformatf("tmo edge trap c%0d", c), 32'(trap1), 32'd0);
            @(posedge clk);
            #1;
        end

        // lw with 3 wait states in MEMRD, then jalr; then reset in the middle of a store
        apply_reset();
        run_instr(LD, 1'b0, 0, 3, 1);
        run_instr(JR, 1'b0, 0, 0, 1);
        op = ST;
        for (int c = 0; c < 4; c++) begin
            apply_stimulus(c == 0, 1'b0);
            @(negedge clk);
            if (c < 3) begin
                @(posedge clk);
                #1;
            end
        end
        check_output("memwr req", 32'({bus1.mem_req, mw1}), 32'h3);
        #2 rst_n = 1'b0;
        #1 check_output("rst abort dut1", 32'({bus1.mem_req, mw1}), 32'h0);
        check_output("rst abort dut0", 32'({bus0.mem_req, mw0}), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_output("restart fetch", 32'(act1), 32'(w(7'b1000000, 2'b00, 2'b10, 2'b10, 2'b00)));
        @(posedge clk);
        #1;

        // Random instruction stream with random wait states and unit latency
        apply_reset();
        for (int n = 0; n < 60; n++) begin
            run_instr(legal[$urandom_range(0, 9)], 1'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(1, 4));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_main_fsm.md
# mc_main_fsm

Multicycle main controller for the RV32I core: a Moore/Mealy FSM that replaces the single-cycle combinational main decoder. It sequences fetch, decode, execute, memory and writeback over several cycles, stalls on a ready handshake for SPI-backed or slow memory, and optionally sequences a multicycle M-extension unit. It sits between the instruction register and the shared datapath muxes (PC, address, ALU sources, result).

## Interface
Parameters:
- ENABLE_M, default 0: 1 routes R-type with funct7 bit 0 set to the mul/div unit.
- MEM_TIMEOUT, default 255: maximum wait cycles for mem_ready before a bus trap; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- op  in  7  opcode from instruction register
- funct7_b0  in  1  instruction bit 25
- mem_ready  in  1  memory accepts/returns this cycle
- md_done  in  1  mul/div result valid (1-cycle pulse)
- mem_req  out  1  memory access request
- PCWrite, IRWrite, RegWrite, MemWrite, Branch, AdrSrc  out  1 each
- ALUSrcA, ALUSrcB, ResultSrc, ALUOp  out  2 each
- ImmSrc  out  3
- md_start  out  1  1-cycle mul/div launch
- trap  out  1; trap_cause  out  2 (01 illegal op, 10 bus timeout)

## Operation
- Encodings: ALUSrcA 00 PC, 01 OldPC, 10 RegA, 11 zero. ALUSrcB 00 RegB, 01 Imm, 10 const 4. ResultSrc 00 ALUOut, 01 Data, 10 ALUResult, 11 mul/div result. ALUOp 00 add, 01 branch compare, 10 funct-decoded.
- ImmSrc is combinational from op in every state: S 001, B 010, J 011, U 100, else 000.
- Unlisted outputs are 0 in each state.
- FETCH: mem_req, AdrSrc=0, SrcA=00, SrcB=10, ResultSrc=10. On mem_ready: IRWrite=1, PCWrite=1, go to DECODE.
- DECODE: SrcA=01, SrcB=01. Next state:
  - load/store -> MEMADR
  - R-type -> EXR; when ENABLE_M and funct7_b0, -> MDWAIT with md_start=1 this cycle
  - I-ALU -> EXI; branch -> BRANCH; JAL -> JAL; JALR -> JALR
  - LUI/AUIPC -> UPPER
  - other -> TRAP, cause 01
- MEMADR: SrcA=10, SrcB=01. Load -> MEMRD; store -> MEMWR.
- MEMRD: mem_req, AdrSrc=1. On ready -> MEMWB. MEMWB: ResultSrc=01, RegWrite -> FETCH.
- MEMWR: mem_req, AdrSrc=1, MemWrite. On ready -> FETCH.
- EXR: SrcA=10, SrcB=00, ALUOp=10. EXI: SrcA=10, SrcB=01, ALUOp=10. Both -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite -> FETCH.
- BRANCH: SrcA=10, SrcB=00, ALUOp=01, ResultSrc=00, Branch -> FETCH.
- JAL: SrcA=01, SrcB=10, ResultSrc=00, PCWrite -> ALUWB.
- JALR: SrcA=10, SrcB=01, ResultSrc=10, PCWrite -> JALRLINK. JALRLINK: SrcA=01, SrcB=10, ResultSrc=10, RegWrite -> FETCH.
- UPPER: SrcA=11 (LUI) or 01 (AUIPC), SrcB=01 -> ALUWB.
- MDWAIT: hold. On md_done: ResultSrc=11, RegWrite -> FETCH. No timeout applies.
- TRAP: trap=1, trap_cause held, all other outputs 0. Left only by reset.

## Timing
- Reset (async, rst_n low): state FETCH, wait counter 0, trap_cause 00. All outputs 0 while asserted except combinational ImmSrc. First cycle after release drives FETCH outputs.
- Reset mid-access drops mem_req immediately and aborts the access.
- Handshake: mem_req stays high until mem_ready. Transfer and state advance happen in the mem_ready cycle. mem_ready without mem_req is ignored.
- Wait counter clears on entry to FETCH, MEMRD or MEMWR and increments on each non-ready cycle. If it equals MEM_TIMEOUT with mem_ready low -> TRAP, cause 10. mem_ready in that same cycle wins.
- Latency at zero-wait memory: ALU op 4 cycles, load 5, store 4, branch 3, JAL 4, JALR 4, upper 4, mul/div 2 plus unit latency.

## Structure
- Package mc_ctrl_pkg: opcode constants, 4-bit state enum (16 states), mux-select encodings, trap-cause constants.
- Sub-module imm_src_dec: combinational op -> ImmSrc, shared with the legacy single-cycle core.

## Test plan
- add (op 0110011), mem_ready tied 1 -> FETCH, DECODE, EXR, ALUWB. RegWrite=1 only in cycle 4, ALUOp=10 in cycle 3.
- lw with mem_ready low 3 cycles in MEMRD -> mem_req held 4 cycles, MEMWB follows, 8 cycles total.
- MEM_TIMEOUT=4, mem_ready never asserts in FETCH -> trap=1, trap_cause=10 after 4 wait cycles. Stays trapped until rst_n pulse.
- op 0000000 -> TRAP with cause 01 in the cycle after DECODE.
- ENABLE_M=1, mul (funct7_b0=1) -> md_start pulses once in DECODE. md_done after 5 cycles -> RegWrite with ResultSrc=11. With ENABLE_M=0 the same instruction takes the EXR path.
- jalr, then rst_n dropped mid-MEMWR -> jalr shows PCWrite in JALR and RegWrite in JALRLINK. The reset drops mem_req/MemWrite to 0 asynchronously and restarts at FETCH.
